// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_arbiter
// Purpose  : Shares one SDRAM read channel between the four ROM fetch ports
//            of the game core (tiles, sprites, theme audio, 68k program).
//            Request pulses are latched per port, arbitrated by fixed
//            priority (tiles > sprites > m68k > theme), and served one read
//            at a time. Each port's returned word lands in its own holding
//            register. The 68k port additionally drives sdram_dtack.
// Ports    : clk_sys, reset            - clock, async active-high reset
//            <port>_rom_req/addr/dout  - per-port request, word address, data
//            sdram_dtack               - 0 while a 68k fetch is outstanding
//            sd_rd/sd_addr             - SDRAM read request (level), byte addr
//            sd_valid/sd_dout          - SDRAM read return
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_arbiter #(
    parameter logic [24:0] TILES_BASE = 25'h0000000,
    parameter logic [24:0] SPR_BASE   = 25'h0100000,
    parameter logic [24:0] THEME_BASE = 25'h0300000,
    parameter logic [24:0] M68K_BASE  = 25'h0400000
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        tiles_rom_req,
    input  logic [17:0] tiles_rom_addr,
    output logic [31:0] tiles_rom_dout,

    input  logic        spr_rom_req,
    input  logic [18:0] spr_rom_addr,
    output logic [31:0] spr_rom_dout,

    input  logic        theme_rom_req,
    input  logic [17:0] theme_rom_addr,
    output logic [31:0] theme_rom_dout,

    input  logic        m68k_rom_req,
    input  logic [17:0] m68k_rom_addr,
    output logic [15:0] m68k_rom_dout,
    output logic        sdram_dtack,

    output logic        sd_rd,
    output logic [24:0] sd_addr,
    input  logic        sd_valid,
    input  logic [31:0] sd_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Port identifiers double as bit positions in the pending vector.
    localparam logic [1:0] c_PORT_TILES = 2'd0;
    localparam logic [1:0] c_PORT_SPR   = 2'd1;
    localparam logic [1:0] c_PORT_THEME = 2'd2;
    localparam logic [1:0] c_PORT_M68K  = 2'd3;

    state_t      r_state_q,       w_state_d;
    logic [3:0]  r_pend_q,        w_pend_d;
    logic [17:0] r_tiles_addr_q,  w_tiles_addr_d;
    logic [18:0] r_spr_addr_q,    w_spr_addr_d;
    logic [17:0] r_theme_addr_q,  w_theme_addr_d;
    logic [17:0] r_m68k_addr_q,   w_m68k_addr_d;
    logic [1:0]  r_port_q,        w_port_d;
    logic        r_half_q,        w_half_d;
    logic        r_sd_rd_q,       w_sd_rd_d;
    logic [24:0] r_sd_addr_q,     w_sd_addr_d;
    logic [31:0] r_tiles_dout_q,  w_tiles_dout_d;
    logic [31:0] r_spr_dout_q,    w_spr_dout_d;
    logic [31:0] r_theme_dout_q,  w_theme_dout_d;
    logic [15:0] r_m68k_dout_q,   w_m68k_dout_d;
    logic        r_dtack_q,       w_dtack_d;

    logic        w_grant;
    logic [1:0]  w_gport;
    logic [24:0] w_gaddr;
    logic [3:0]  w_pend_clr;
    logic        w_wr_en;
    logic [3:0]  w_req_vec;

    logic [24:0] w_tiles_sd;
    logic [24:0] w_spr_sd;
    logic [24:0] w_theme_sd;
    logic [24:0] w_m68k_sd;

    assign w_req_vec = {m68k_rom_req, theme_rom_req, spr_rom_req, tiles_rom_req};

    // Byte addresses; the sums wrap at 25 bits. The 68k fetches the 32-bit
    // word holding its 16-bit word and picks the half on return.
    assign w_tiles_sd = TILES_BASE + {5'd0, r_tiles_addr_q, 2'b00};
    assign w_spr_sd   = SPR_BASE   + {4'd0, r_spr_addr_q, 2'b00};
    assign w_theme_sd = THEME_BASE + {5'd0, r_theme_addr_q, 2'b00};
    assign w_m68k_sd  = M68K_BASE  + {6'd0, r_m68k_addr_q[17:1], 2'b00};

    // Address capture: a new request always overwrites the latched address.
    assign w_tiles_addr_d = tiles_rom_req ? tiles_rom_addr : r_tiles_addr_q;
    assign w_spr_addr_d   = spr_rom_req   ? spr_rom_addr   : r_spr_addr_q;
    assign w_theme_addr_d = theme_rom_req ? theme_rom_addr : r_theme_addr_q;
    assign w_m68k_addr_d  = m68k_rom_req  ? m68k_rom_addr  : r_m68k_addr_q;

    // Fixed-priority winner among pending ports.
    always_comb begin
        w_grant = 1'b0;
        w_gport = c_PORT_TILES;
        w_gaddr = w_tiles_sd;
        if (r_pend_q[c_PORT_TILES]) begin
            w_grant = 1'b1;
            w_gport = c_PORT_TILES;
            w_gaddr = w_tiles_sd;
        end else if (r_pend_q[c_PORT_SPR]) begin
            w_grant = 1'b1;
            w_gport = c_PORT_SPR;
            w_gaddr = w_spr_sd;
        end else if (r_pend_q[c_PORT_M68K]) begin
            w_grant = 1'b1;
            w_gport = c_PORT_M68K;
            w_gaddr = w_m68k_sd;
        end else if (r_pend_q[c_PORT_THEME]) begin
            w_grant = 1'b1;
            w_gport = c_PORT_THEME;
            w_gaddr = w_theme_sd;
        end
    end

    // Transaction FSM: next state and registered SDRAM request.
    always_comb begin
        w_state_d   = r_state_q;
        w_sd_rd_d   = r_sd_rd_q;
        w_sd_addr_d = r_sd_addr_q;
        w_port_d    = r_port_q;
        w_half_d    = r_half_q;
        w_pend_clr  = 4'b0000;
        w_wr_en     = 1'b0;
        case (r_state_q)
            // DONE is the single cycle with sd_rd low after a return; it
            // arbitrates like IDLE so a waiting port is re-issued after
            // exactly that one-cycle gap (sd_rd high two cycles after
            // sd_valid). With nothing pending it settles in IDLE.
            IDLE, DONE: begin
                w_sd_rd_d = 1'b0;
                w_state_d = IDLE;
                if (w_grant) begin
                    w_state_d           = WAIT;
                    w_sd_rd_d           = 1'b1;
                    w_sd_addr_d         = w_gaddr;
                    w_port_d            = w_gport;
                    w_half_d            = r_m68k_addr_q[0];
                    w_pend_clr[w_gport] = 1'b1;
                end
            end
            WAIT: begin
                if (sd_valid) begin
                    w_wr_en   = 1'b1;
                    w_sd_rd_d = 1'b0;
                    w_state_d = DONE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_sd_rd_d = 1'b0;
            end
        endcase
    end

    // A request arriving on the grant edge re-arms the flag, so capture
    // takes precedence over the grant's clear.
    assign w_pend_d = (r_pend_q & ~w_pend_clr) | w_req_vec;

    // Holding registers: only the port owning the transaction is written.
    always_comb begin
        w_tiles_dout_d = r_tiles_dout_q;
        w_spr_dout_d   = r_spr_dout_q;
        w_theme_dout_d = r_theme_dout_q;
        w_m68k_dout_d  = r_m68k_dout_q;
        if (w_wr_en) begin
            case (r_port_q)
                c_PORT_TILES: w_tiles_dout_d = sd_dout;
                c_PORT_SPR:   w_spr_dout_d   = sd_dout;
                c_PORT_THEME: w_theme_dout_d = sd_dout;
                default:      w_m68k_dout_d  = r_half_q ? sd_dout[31:16] : sd_dout[15:0];
            endcase
        end
    end

    // A fresh 68k request wins over a delivery on the same edge so the CPU
    // keeps waiting for the newly requested word.
    always_comb begin
        w_dtack_d = r_dtack_q;
        if (m68k_rom_req) begin
            w_dtack_d = 1'b0;
        end else if (w_wr_en && (r_port_q == c_PORT_M68K)) begin
            w_dtack_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_pend_q       <= 4'b0000;
            r_tiles_addr_q <= 18'd0;
            r_spr_addr_q   <= 19'd0;
            r_theme_addr_q <= 18'd0;
            r_m68k_addr_q  <= 18'd0;
            r_port_q       <= c_PORT_TILES;
            r_half_q       <= 1'b0;
            r_sd_rd_q      <= 1'b0;
            r_sd_addr_q    <= 25'd0;
            r_tiles_dout_q <= 32'd0;
            r_spr_dout_q   <= 32'd0;
            r_theme_dout_q <= 32'd0;
            r_m68k_dout_q  <= 16'd0;
            r_dtack_q      <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_pend_q       <= w_pend_d;
            r_tiles_addr_q <= w_tiles_addr_d;
            r_spr_addr_q   <= w_spr_addr_d;
            r_theme_addr_q <= w_theme_addr_d;
            r_m68k_addr_q  <= w_m68k_addr_d;
            r_port_q       <= w_port_d;
            r_half_q       <= w_half_d;
            r_sd_rd_q      <= w_sd_rd_d;
            r_sd_addr_q    <= w_sd_addr_d;
            r_tiles_dout_q <= w_tiles_dout_d;
            r_spr_dout_q   <= w_spr_dout_d;
            r_theme_dout_q <= w_theme_dout_d;
            r_m68k_dout_q  <= w_m68k_dout_d;
            r_dtack_q      <= w_dtack_d;
        end
    end

    assign tiles_rom_dout = r_tiles_dout_q;
    assign spr_rom_dout   = r_spr_dout_q;
    assign theme_rom_dout = r_theme_dout_q;
    assign m68k_rom_dout  = r_m68k_dout_q;
    assign sdram_dtack    = r_dtack_q;
    assign sd_rd          = r_sd_rd_q;
    assign sd_addr        = r_sd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_arbiter
// Purpose  : Self-checking bench for rom_fetch_arbiter. An SDRAM responder
//            logs every issued read and returns random data after a chosen
//            latency; expectations come from the address formulas, the
//            priority order and a per-port holding-register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_arbiter;

    localparam logic [24:0] c_TILES_BASE = 25'h0000000;
    localparam logic [24:0] c_SPR_BASE   = 25'h0100000;
    localparam logic [24:0] c_THEME_BASE = 25'h0300000;
    localparam logic [24:0] c_M68K_BASE  = 25'h0400000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        tiles_rom_req, spr_rom_req, theme_rom_req, m68k_rom_req;
    logic [17:0] tiles_rom_addr, theme_rom_addr, m68k_rom_addr;
    logic [18:0] spr_rom_addr;
    logic [31:0] tiles_rom_dout, spr_rom_dout, theme_rom_dout;
    logic [15:0] m68k_rom_dout;
    logic        sdram_dtack, sd_rd, sd_valid;
    logic [24:0] sd_addr;
    logic [31:0] sd_dout;

    always #5 clk_sys = ~clk_sys;

    rom_fetch_arbiter #(
        .TILES_BASE (c_TILES_BASE),
        .SPR_BASE   (c_SPR_BASE),
        .THEME_BASE (c_THEME_BASE),
        .M68K_BASE  (c_M68K_BASE)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .tiles_rom_req  (tiles_rom_req),
        .tiles_rom_addr (tiles_rom_addr),
        .tiles_rom_dout (tiles_rom_dout),
        .spr_rom_req    (spr_rom_req),
        .spr_rom_addr   (spr_rom_addr),
        .spr_rom_dout   (spr_rom_dout),
        .theme_rom_req  (theme_rom_req),
        .theme_rom_addr (theme_rom_addr),
        .theme_rom_dout (theme_rom_dout),
        .m68k_rom_req   (m68k_rom_req),
        .m68k_rom_addr  (m68k_rom_addr),
        .m68k_rom_dout  (m68k_rom_dout),
        .sdram_dtack    (sdram_dtack),
        .sd_rd          (sd_rd),
        .sd_addr        (sd_addr),
        .sd_valid       (sd_valid),
        .sd_dout        (sd_dout)
    );

    int checks   = 0;
    int failures = 0;

    // SDRAM responder state and transaction log.
    int          lat        = 1;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_data = 32'd0;
    bit          busy       = 1'b0;
    int          done_count = 0;
    int          unstable   = 0;
    logic [24:0] txn_addr[$];
    logic [31:0] txn_data[$];

    // Holding-register model, indexed 0 tiles, 1 sprites, 2 theme, 3 m68k.
    logic [31:0] exp_dout[4];
    int          prio[4] = '{0, 1, 3, 2};

    initial begin : sdram_model
        int          cnt;
        logic        prev_rd;
        logic [31:0] data;
        logic [24:0] held;
        cnt = 0; prev_rd = 1'b0; data = 32'd0; held = 25'd0;
        sd_valid = 1'b0;
        sd_dout  = 32'd0;
        forever begin
            @(negedge clk_sys);
            sd_valid = 1'b0;
            if (busy && sd_rd && (sd_addr !== held)) unstable++;
            if (!busy && sd_rd && !prev_rd) begin
                busy = 1'b1;
                cnt  = lat;
                held = sd_addr;
                data = use_fixed ? fixed_data : $urandom;
                txn_addr.push_back(sd_addr);
                txn_data.push_back(data);
            end
            if (busy) begin
                if (cnt == 0) begin
                    sd_valid = 1'b1;
                    sd_dout  = data;
                    busy     = 1'b0;
                    done_count++;
                end else begin
                    cnt--;
                end
            end
            prev_rd = sd_rd;
        end
    end

    function automatic logic [24:0] exp_addr(input int port, input logic [18:0] a);
        logic [31:0] off;
        logic [31:0] sum;
        off = 32'(a) * 4;
        case (port)
            0:       sum = {7'd0, c_TILES_BASE} + off;
            1:       sum = {7'd0, c_SPR_BASE} + off;
            2:       sum = {7'd0, c_THEME_BASE} + off;
            default: sum = {7'd0, c_M68K_BASE} + (32'(a) / 2) * 4;
        endcase
        return sum[24:0];
    endfunction

    function automatic logic [31:0] exp_word(input int port, input logic [18:0] a, input logic [31:0] d);
        if (port != 3) return d;
        return (a % 2 == 1) ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
    endfunction

    function automatic logic [31:0] get_dout(input int port);
        case (port)
            0:       return tiles_rom_dout;
            1:       return spr_rom_dout;
            2:       return theme_rom_dout;
            default: return {16'd0, m68k_rom_dout};
        endcase
    endfunction

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        txn_addr.delete();
        txn_data.delete();
        done_count = 0;
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [18:0] a0, input logic [18:0] a1,
                         input logic [18:0] a2, input logic [18:0] a3);
        tick();
        tiles_rom_req = mask[0]; tiles_rom_addr = a0[17:0];
        spr_rom_req   = mask[1]; spr_rom_addr   = a1;
        theme_rom_req = mask[2]; theme_rom_addr = a2[17:0];
        m68k_rom_req  = mask[3]; m68k_rom_addr  = a3[17:0];
        tick();
        tiles_rom_req = 1'b0; spr_rom_req = 1'b0; theme_rom_req = 1'b0; m68k_rom_req = 1'b0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_count >= n) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sd_rd) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL reset_sd_rd actual=%0h required=0", sd_rd); end
        checks++; if (sd_addr !== 25'd0) begin failures++; $display("FAIL reset_sd_addr actual=%0h required=0", sd_addr); end
        checks++; if (sdram_dtack !== 1'b1) begin failures++; $display("FAIL reset_dtack actual=%0h required=1", sdram_dtack); end
        for (int p = 0; p < 4; p++) begin
            exp_dout[p] = 32'd0;
            checks++;
            if (get_dout(p) !== 32'd0) begin failures++; $display("FAIL reset_dout%0d actual=%0h required=0", p, get_dout(p)); end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_m68k();
        int cyc;
        int bad;
        clear_log();
        lat = 5; use_fixed = 1'b1; fixed_data = 32'hAABB_CCDD;
        tick();
        m68k_rom_req = 1'b1; m68k_rom_addr = 18'h00003;
        tick();
        m68k_rom_req = 1'b0;
        checks++; if (sdram_dtack !== 1'b0) begin failures++; $display("FAIL m68k_dtack_low actual=%0h required=0", sdram_dtack); end
        cyc = 1; bad = 0;
        while ((m68k_rom_dout !== 16'hAABB) && (cyc < 60)) begin
            if (sdram_dtack !== 1'b0) bad++;
            tick();
            cyc++;
        end
        use_fixed = 1'b0;
        exp_dout[3] = 32'h0000_AABB;
        checks++; if (m68k_rom_dout !== 16'hAABB) begin failures++; $display("FAIL m68k_dout actual=%0h required=aabb", m68k_rom_dout); end
        checks++; if (cyc != 3 + lat) begin failures++; $display("FAIL m68k_latency actual=%0d required=%0d", cyc, 3 + lat); end
        checks++; if (bad != 0) begin failures++; $display("FAIL m68k_dtack_held actual=%0d_high_cycles required=0", bad); end
        checks++; if (sdram_dtack !== 1'b1) begin failures++; $display("FAIL m68k_dtack_release actual=%0h required=1", sdram_dtack); end
        checks++;
        if ((txn_addr.size() != 1) || (txn_addr[0] !== 25'h0400004)) begin
            failures++;
            $display("FAIL m68k_sd_addr actual=%0h count=%0d required=0400004 count=1",
                     (txn_addr.size() > 0) ? txn_addr[0] : 25'd0, txn_addr.size());
        end
        checks++; if (tiles_rom_dout !== exp_dout[0]) begin failures++; $display("FAIL m68k_tiles_untouched actual=%0h required=%0h", tiles_rom_dout, exp_dout[0]); end
        tick();
    endtask

    task automatic test_priority();
        logic [18:0] a[4];
        int          prev_done;
        int          bad;
        bit          ok;
        clear_log();
        lat = $urandom_range(1, 4);
        a[0] = 19'($urandom_range(0, 32'h3FFFF));
        a[1] = 19'($urandom_range(0, 32'h7FFFF));
        a[2] = 19'($urandom_range(0, 32'h3FFFF));
        a[3] = 19'($urandom_range(0, 32'h3FFFF));
        pulse(4'b1111, a[0], a[1], a[2], a[3]);
        prev_done = 0; bad = 0; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sdram_dtack !== 1'(prev_done >= 3)) bad++;
            if (prev_done >= 4) begin ok = 1'b1; break; end
            prev_done = done_count;
            tick();
        end
        checks++; if (!ok) begin failures++; $display("FAIL prio_timeout actual=%0d_done required=4", done_count); end
        checks++; if (bad != 0) begin failures++; $display("FAIL prio_dtack actual=%0d_bad_cycles required=0", bad); end
        checks++; if (txn_addr.size() != 4) begin failures++; $display("FAIL prio_count actual=%0d required=4", txn_addr.size()); end
        for (int k = 0; k < 4 && k < txn_addr.size(); k++) begin
            checks++;
            if (txn_addr[k] !== exp_addr(prio[k], a[prio[k]])) begin
                failures++;
                $display("FAIL prio_addr%0d actual=%0h required=%0h", k, txn_addr[k], exp_addr(prio[k], a[prio[k]]));
            end
            exp_dout[prio[k]] = exp_word(prio[k], a[prio[k]], txn_data[k]);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (get_dout(p) !== exp_dout[p]) begin failures++; $display("FAIL prio_dout%0d actual=%0h required=%0h", p, get_dout(p), exp_dout[p]); end
        end
    endtask

    task automatic test_rereq_inflight();
        bit ok;
        clear_log();
        lat = 4;
        pulse(4'b0010, 19'd0, 19'h00010, 19'd0, 19'd0);
        wait_rd(ok);
        checks++; if (!ok || done_count != 0) begin failures++; $display("FAIL rereq_first_issue actual=%0h required=1", sd_rd); end
        pulse(4'b0010, 19'd0, 19'h00020, 19'd0, 19'd0);
        wait_done(2, ok);
        checks++; if (!ok || txn_addr.size() != 2) begin failures++; $display("FAIL rereq_count actual=%0d required=2", txn_addr.size()); end
        if (txn_addr.size() == 2) begin
            checks++; if (txn_addr[0] !== 25'h0100040) begin failures++; $display("FAIL rereq_addr0 actual=%0h required=0100040", txn_addr[0]); end
            checks++; if (txn_addr[1] !== 25'h0100080) begin failures++; $display("FAIL rereq_addr1 actual=%0h required=0100080", txn_addr[1]); end
            exp_dout[1] = txn_data[1];
            checks++; if (spr_rom_dout !== exp_dout[1]) begin failures++; $display("FAIL rereq_dout actual=%0h required=%0h", spr_rom_dout, exp_dout[1]); end
        end
    endtask

    task automatic test_coalesce();
        logic [18:0] ta, a1, a2;
        bit          ok;
        clear_log();
        lat = 6;
        ta = 19'($urandom_range(0, 32'h3FFFF));
        a1 = 19'($urandom_range(0, 32'h1FFFF));
        a2 = a1 + 19'h20000;
        pulse(4'b0001, ta, 19'd0, 19'd0, 19'd0);
        wait_rd(ok);
        pulse(4'b0100, 19'd0, 19'd0, a1, 19'd0);
        pulse(4'b0100, 19'd0, 19'd0, a2, 19'd0);
        wait_done(2, ok);
        repeat (6) tick();
        checks++; if (txn_addr.size() != 2) begin failures++; $display("FAIL coalesce_count actual=%0d required=2", txn_addr.size()); end
        if (txn_addr.size() == 2) begin
            checks++; if (txn_addr[0] !== exp_addr(0, ta)) begin failures++; $display("FAIL coalesce_tiles_addr actual=%0h required=%0h", txn_addr[0], exp_addr(0, ta)); end
            checks++; if (txn_addr[1] !== exp_addr(2, a2)) begin failures++; $display("FAIL coalesce_theme_addr actual=%0h required=%0h", txn_addr[1], exp_addr(2, a2)); end
            exp_dout[0] = txn_data[0];
            exp_dout[2] = txn_data[1];
            checks++; if (theme_rom_dout !== exp_dout[2]) begin failures++; $display("FAIL coalesce_dout actual=%0h required=%0h", theme_rom_dout, exp_dout[2]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] a, b;
        int          phase;
        int          low;
        bit          ok;
        clear_log();
        lat = 0;
        a = 18'($urandom); b = 18'($urandom);
        tick();
        tiles_rom_req = 1'b1; tiles_rom_addr = a;
        tick();
        tiles_rom_addr = b;
        tick();
        tiles_rom_req = 1'b0;
        phase = 0; low = 0;
        for (int i = 0; i < 40; i++) begin
            case (phase)
                0: if (sd_rd) phase = 1;
                1: if (!sd_rd) begin phase = 2; low = 1; end
                2: if (sd_rd) phase = 3; else low++;
                default: ;
            endcase
            if (phase == 3) break;
            tick();
        end
        wait_done(2, ok);
        checks++; if (phase != 3 || low != 1) begin failures++; $display("FAIL b2b_gap actual=%0d_low_cycles required=1", low); end
        checks++; if (txn_addr.size() != 2) begin failures++; $display("FAIL b2b_count actual=%0d required=2", txn_addr.size()); end
        if (txn_addr.size() == 2) begin
            checks++; if (txn_addr[1] !== exp_addr(0, 19'(b))) begin failures++; $display("FAIL b2b_addr1 actual=%0h required=%0h", txn_addr[1], exp_addr(0, 19'(b))); end
            exp_dout[0] = txn_data[1];
            checks++; if (tiles_rom_dout !== exp_dout[0]) begin failures++; $display("FAIL b2b_dout actual=%0h required=%0h", tiles_rom_dout, exp_dout[0]); end
        end
    endtask

    task automatic test_random();
        logic [18:0] a[4];
        logic [3:0]  mask;
        int          order[$];
        bit          ok;
        for (int r = 0; r < 16; r++) begin
            clear_log();
            lat  = $urandom_range(0, 5);
            mask = 4'($urandom_range(1, 15));
            a[0] = 19'($urandom_range(0, 32'h3FFFF));
            a[1] = 19'($urandom_range(0, 32'h7FFFF));
            a[2] = 19'($urandom_range(0, 32'h3FFFF));
            a[3] = 19'($urandom_range(0, 32'h3FFFF));
            order.delete();
            for (int k = 0; k < 4; k++) if (mask[prio[k]]) order.push_back(prio[k]);
            pulse(mask, a[0], a[1], a[2], a[3]);
            wait_done(order.size(), ok);
            checks++;
            if (!ok || txn_addr.size() != order.size()) begin
                failures++;
                $display("FAIL rand%0d_count actual=%0d required=%0d", r, txn_addr.size(), order.size());
            end else begin
                for (int k = 0; k < order.size(); k++) begin
                    checks++;
                    if (txn_addr[k] !== exp_addr(order[k], a[order[k]])) begin
                        failures++;
                        $display("FAIL rand%0d_addr%0d actual=%0h required=%0h", r, k, txn_addr[k], exp_addr(order[k], a[order[k]]));
                    end
                    exp_dout[order[k]] = exp_word(order[k], a[order[k]], txn_data[k]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (get_dout(p) !== exp_dout[p]) begin failures++; $display("FAIL rand%0d_dout%0d actual=%0h required=%0h", r, p, get_dout(p), exp_dout[p]); end
            end
            checks++; if (sdram_dtack !== 1'b1) begin failures++; $display("FAIL rand%0d_dtack actual=%0h required=1", r, sdram_dtack); end
        end
        checks++; if (unstable != 0) begin failures++; $display("FAIL addr_stable_in_wait actual=%0d_changes required=0", unstable); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        clear_log();
        lat = 8;
        pulse(4'b1000, 19'd0, 19'd0, 19'd0, 19'($urandom_range(0, 32'h3FFFF)));
        wait_rd(ok);
        checks++; if (!ok || sdram_dtack !== 1'b0) begin failures++; $display("FAIL rst_pre_dtack actual=%0h required=0", sdram_dtack); end
        reset = 1'b1;
        #1;
        checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL rst_sd_rd actual=%0h required=0", sd_rd); end
        checks++; if (sdram_dtack !== 1'b1) begin failures++; $display("FAIL rst_dtack actual=%0h required=1", sdram_dtack); end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        repeat (4) tick();
        checks++; if (done_count != 1) begin failures++; $display("FAIL rst_late_valid actual=%0d_pulses required=1", done_count); end
        for (int p = 0; p < 4; p++) begin
            exp_dout[p] = 32'd0;
            checks++;
            if (get_dout(p) !== 32'd0) begin failures++; $display("FAIL rst_dout%0d actual=%0h required=0", p, get_dout(p)); end
        end
        checks++; if (txn_addr.size() != 1 || sd_rd !== 1'b0) begin failures++; $display("FAIL rst_no_reissue actual=%0d_txns required=1", txn_addr.size()); end
    endtask

    initial begin
        reset = 1'b1;
        tiles_rom_req = 1'b0; spr_rom_req = 1'b0; theme_rom_req = 1'b0; m68k_rom_req = 1'b0;
        tiles_rom_addr = 18'd0; spr_rom_addr = 19'd0; theme_rom_addr = 18'd0; m68k_rom_addr = 18'd0;
        test_reset();
        test_single_m68k();
        test_priority();
        test_rereq_inflight();
        test_coalesce();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
